uart_sample_tx: RTL and testbench

Serial output stage that sits directly downstream of the sample FIFO and drains it to the host over a UART link. Whenever the FIFO presents a valid word, the block takes it with a one-cycle read pulse. It then transmits the word as two 8N1 UART bytes: a high byte with a sync marker, followed by a low byte. The host PC uses the marker bit to realign the byte stream into DATA_WIDTH-bit samples.

---
 rtl/uart_sample_tx_if.sv | 21 ++
 rtl/uart_sample_tx.sv | 111 +++++++++++
 tb/tb_uart_sample_tx.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_sample_tx_if.sv
// FIFO-to-UART link: head-of-FIFO handshake plus serial line and busy status.
// The slave modport is the transmitter, the master modport is the FIFO/host side.
interface uart_sample_tx_if #(
  parameter int DATA_WIDTH = 9
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_read;
  logic                  tx;
  logic                  busy;

  modport master (
    output in_data, in_valid,
    input  in_read, tx, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_read, tx, busy
  );
endinterface

// File: rtl/uart_sample_tx.sv
// Drains one FIFO word at a time and sends it as two 8N1 bytes: a marked high
// byte (bit 7 set) followed by the low seven bits, so the host can realign.
module uart_sample_tx #(
  parameter int DATA_WIDTH   = 9,
  parameter int CLKS_PER_BIT = 868
) (
  input logic              clk,
  input logic              rst,
  uart_sample_tx_if.slave  bus
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] word;
  logic                  byte_idx;
  logic [2:0]            bit_idx;
  logic [CW-1:0]         baud_cnt;

  logic [7:0] byte0;
  logic [7:0] byte1;
  logic [7:0] cur_byte;
  logic [2:0] next_bit;
  logic       baud_done;

  // High byte carries the marker plus the bits above the low seven, zero-padded.
  assign byte0     = 8'h80 | 8'(word >> 7);
  assign byte1     = {1'b0, word[6:0]};
  assign cur_byte  = byte_idx ? byte1 : byte0;
  assign next_bit  = bit_idx + 3'd1;
  assign baud_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      word        <= '0;
      byte_idx    <= 1'b0;
      bit_idx     <= 3'd0;
      baud_cnt    <= '0;
      bus.tx      <= 1'b1;
      bus.in_read <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      bus.in_read <= 1'b0;
      case (state)
        IDLE: begin
          bus.tx   <= 1'b1;
          bus.busy <= 1'b0;
          if (bus.in_valid) begin
            word        <= bus.in_data;
            bus.in_read <= 1'b1;
            bus.tx      <= 1'b0;
            bus.busy    <= 1'b1;
            byte_idx    <= 1'b0;
            baud_cnt    <= '0;
            state       <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            bus.tx   <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
              bus.tx  <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= next_bit;
              bus.tx  <= cur_byte[next_bit];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            // Low byte follows the high byte with no gap; after it, one idle cycle minimum.
            if (!byte_idx) begin
              byte_idx <= 1'b1;
              bus.tx   <= 1'b0;
              state    <= START;
            end else begin
              bus.tx   <= 1'b1;
              bus.busy <= 1'b0;
              state    <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          bus.tx   <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_sample_tx.sv
// Directed bench: a fast instance (4 clks/bit) with a FIFO model and a host-side
// byte decoder, plus a full-rate instance (868 clks/bit) for the timing check.
module tb_uart_sample_tx;
  localparam int DW      = 9;
  localparam int CPB     = 4;
  localparam int CPB_S   = 868;
  localparam int LOG_MAX = 512;

  logic clk;
  logic rst;

  uart_sample_tx_if #(.DATA_WIDTH(DW)) bus ();
  uart_sample_tx_if #(.DATA_WIDTH(DW)) bus_s ();

  uart_sample_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  uart_sample_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB_S)) dut_slow (
    .clk (clk),
    .rst (rst),
    .bus (bus_s.slave)
  );

  always #5 clk = ~clk;

  int n_compared;
  int n_mismatched;

  logic [DW-1:0] fifo_q[$];
  logic          tx_log[LOG_MAX];
  logic          rd_log[LOG_MAX];
  logic          busy_log[LOG_MAX];
  int            n_log;
  logic [7:0]    rx_bytes[$];
  int            frame_err;

  task automatic refresh_fifo();
    bus.in_valid = (fifo_q.size() != 0);
    bus.in_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  // One clock of the fast instance: sample after the edge, log, then let the FIFO pop.
  task automatic step();
    @(posedge clk);
    #1;
    if (n_log < LOG_MAX) begin
      tx_log[n_log]   = bus.tx;
      rd_log[n_log]   = bus.in_read;
      busy_log[n_log] = bus.busy;
      n_log++;
    end
    if (bus.in_read === 1'b1 && fifo_q.size() != 0) void'(fifo_q.pop_front());
    refresh_fifo();
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Host-side UART receiver over the logged line, sampling mid-bit.
  task automatic decode_log();
    int i;
    logic [7:0] b;
    rx_bytes.delete();
    frame_err = 0;
    i = 0;
    while (i < n_log) begin
      if (tx_log[i] === 1'b0) begin
        if (i + 10*CPB - 1 >= n_log) begin
          frame_err++;
          break;
        end
        for (int k = 0; k < 8; k++) b[k] = tx_log[i + CPB*(k+1) + CPB/2];
        if (tx_log[i + CPB/2] !== 1'b0 || tx_log[i + 9*CPB + CPB/2] !== 1'b1) frame_err++;
        rx_bytes.push_back(b);
        i += 10*CPB;
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fifo_q.push_back(9'h1A5);
    refresh_fifo();
    n_log = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_compared++;
      if (bus.tx !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL reset_tx cycle %0d: got %b expected 1", c, bus.tx);
      end
      n_compared++;
      if (bus.in_read !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL reset_in_read cycle %0d: got %b expected 0", c, bus.in_read);
      end
      n_compared++;
      if (bus.busy !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL reset_busy cycle %0d: got %b expected 0", c, bus.busy);
      end
    end
    n_compared++;
    if (fifo_q.size() != 1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_no_pop: fifo size %0d expected 1", fifo_q.size());
    end
    fifo_q.delete();
    refresh_fifo();
    rst = 1'b0;
    step_n(2);
    n_compared++;
    if (bus.tx !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_release_idle_tx: got %b expected 1", bus.tx);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] exp_b[2];
    int s, pulses, busy_cnt, pos;
    logic e;
    logic [3:0] obs;
    exp_b[0] = 8'h83;
    exp_b[1] = 8'h25;
    n_log = 0;
    fifo_q.push_back(9'h1A5);
    refresh_fifo();
    step_n(95);
    s = -1;
    pulses = 0;
    busy_cnt = 0;
    for (int i = 0; i < n_log; i++) begin
      if (rd_log[i] === 1'b1) begin
        pulses++;
        if (s < 0) s = i;
      end
      if (busy_log[i] === 1'b1) busy_cnt++;
    end
    n_compared++;
    if (pulses != 1) begin
      n_mismatched++;
      $display("[TB] FAIL single_read_pulses: got %0d expected 1", pulses);
    end
    if (s < 0) s = 0;
    n_compared++;
    if (s != 0) begin
      n_mismatched++;
      $display("[TB] FAIL single_latency: read at cycle %0d expected 0", s);
    end
    for (int b = 0; b < 20; b++) begin
      pos = b % 10;
      e = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : exp_b[b/10][pos-1];
      obs = {tx_log[s+4*b+3], tx_log[s+4*b+2], tx_log[s+4*b+1], tx_log[s+4*b]};
      n_compared++;
      if (obs !== {4{e}}) begin
        n_mismatched++;
        $display("[TB] FAIL single_bit_%0d: got %b expected %b", b, obs, {4{e}});
      end
    end
    n_compared++;
    if (tx_log[s+80] !== 1'b1 || busy_log[s+80] !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL single_end_idle: tx %b busy %b expected tx 1 busy 0",
               tx_log[s+80], busy_log[s+80]);
    end
    n_compared++;
    if (busy_cnt != 80) begin
      n_mismatched++;
      $display("[TB] FAIL single_busy_cycles: got %0d expected 80", busy_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[4];
    int p[$];
    exp_b[0] = 8'h80; exp_b[1] = 8'h00; exp_b[2] = 8'h83; exp_b[3] = 8'h7F;
    n_log = 0;
    fifo_q.push_back(9'h000);
    fifo_q.push_back(9'h1FF);
    refresh_fifo();
    step_n(200);
    for (int i = 0; i < n_log; i++) if (rd_log[i] === 1'b1) p.push_back(i);
    n_compared++;
    if (p.size() != 2) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_read_pulses: got %0d expected 2", p.size());
    end
    n_compared++;
    if (p.size() < 2 || p[1] - p[0] != 81) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_period: got %0d expected 81", (p.size() < 2) ? -1 : p[1] - p[0]);
    end
    n_compared++;
    if (fifo_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_fifo_empty: size %0d expected 0", fifo_q.size());
    end
    decode_log();
    n_compared++;
    if (rx_bytes.size() != 4 || frame_err != 0) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_frames: got %0d bytes %0d errors expected 4 bytes 0 errors",
               rx_bytes.size(), frame_err);
    end
    for (int j = 0; j < 4; j++) begin
      n_compared++;
      if (j >= rx_bytes.size() || rx_bytes[j] !== exp_b[j]) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_byte_%0d: got %h expected %h", j,
                 (j < rx_bytes.size()) ? rx_bytes[j] : 8'hxx, exp_b[j]);
      end
    end
  endtask

  task automatic test_continuous_valid();
    logic [7:0] exp_b[6];
    logic [DW-1:0] words[$];
    int pulses, in_flight;
    exp_b[0] = 8'h82; exp_b[1] = 8'h55;
    exp_b[2] = 8'h81; exp_b[3] = 8'h2A;
    exp_b[4] = 8'h82; exp_b[5] = 8'h7F;
    n_log = 0;
    fifo_q.push_back(9'h155);
    fifo_q.push_back(9'h0AA);
    fifo_q.push_back(9'h17F);
    refresh_fifo();
    step_n(260);
    pulses = 0;
    in_flight = 0;
    for (int i = 0; i < n_log; i++) begin
      if (rd_log[i] === 1'b1) begin
        pulses++;
        if (i > 0 && busy_log[i-1] === 1'b1) in_flight++;
      end
    end
    n_compared++;
    if (pulses != 3) begin
      n_mismatched++;
      $display("[TB] FAIL cont_read_pulses: got %0d expected 3", pulses);
    end
    n_compared++;
    if (in_flight != 0) begin
      n_mismatched++;
      $display("[TB] FAIL cont_read_while_busy: got %0d expected 0", in_flight);
    end
    decode_log();
    for (int j = 0; j < 6; j++) begin
      n_compared++;
      if (j >= rx_bytes.size() || rx_bytes[j] !== exp_b[j]) begin
        n_mismatched++;
        $display("[TB] FAIL cont_byte_%0d: got %h expected %h", j,
                 (j < rx_bytes.size()) ? rx_bytes[j] : 8'hxx, exp_b[j]);
      end
    end
    // Host joins one byte late and must resynchronise on the next marker.
    for (int j = 1; j + 1 < rx_bytes.size(); j++) begin
      if (rx_bytes[j][7]) begin
        words.push_back({rx_bytes[j][1:0], rx_bytes[j+1][6:0]});
        j++;
      end
    end
    n_compared++;
    if (words.size() != 2 || words[0] !== 9'h0AA || words[1] !== 9'h17F) begin
      n_mismatched++;
      $display("[TB] FAIL cont_realign: got %0d words first %h expected 2 words 0aa 17f",
               words.size(), (words.size() > 0) ? words[0] : 9'hxxx);
    end
  endtask

  task automatic test_reset_mid_data();
    int waited;
    n_log = 0;
    fifo_q.push_back(9'h1A5);
    refresh_fifo();
    waited = 0;
    do begin
      step();
      waited++;
    end while (bus.in_read !== 1'b1 && waited < 10);
    n_compared++;
    if (bus.in_read !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL mid_read_timeout: got %b expected 1", bus.in_read);
    end
    step_n(CPB + 2*CPB);
    n_compared++;
    if (bus.busy !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL mid_busy_before_reset: got %b expected 1", bus.busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_compared++;
    if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.in_read !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL mid_reset_outputs: tx %b busy %b in_read %b expected 1 0 0",
               bus.tx, bus.busy, bus.in_read);
    end
    n_log = 0;
    fifo_q.push_back(9'h0C3);
    refresh_fifo();
    step_n(100);
    decode_log();
    n_compared++;
    if (rx_bytes.size() != 2 || frame_err != 0) begin
      n_mismatched++;
      $display("[TB] FAIL mid_next_frames: got %0d bytes %0d errors expected 2 bytes 0 errors",
               rx_bytes.size(), frame_err);
    end
    n_compared++;
    if (rx_bytes.size() < 2 || rx_bytes[0] !== 8'h81 || rx_bytes[1] !== 8'h43) begin
      n_mismatched++;
      $display("[TB] FAIL mid_next_bytes: got %h %h expected 81 43",
               (rx_bytes.size() > 0) ? rx_bytes[0] : 8'hxx,
               (rx_bytes.size() > 1) ? rx_bytes[1] : 8'hxx);
    end
  endtask

  task automatic test_full_rate();
    int waited, low_run, busy_cyc;
    logic still_low;
    bus_s.in_data  = 9'h0F0;
    bus_s.in_valid = 1'b1;
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (bus_s.in_read !== 1'b1 && waited < 10);
    bus_s.in_valid = 1'b0;
    n_compared++;
    if (bus_s.in_read !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL full_read_timeout: got %b expected 1", bus_s.in_read);
    end
    low_run   = (bus_s.tx === 1'b0) ? 1 : 0;
    still_low = (bus_s.tx === 1'b0);
    busy_cyc  = (bus_s.busy === 1'b1) ? 1 : 0;
    for (int c = 0; c < 20*CPB_S + 100; c++) begin
      @(posedge clk);
      #1;
      if (bus_s.busy !== 1'b1) break;
      busy_cyc++;
      if (still_low && bus_s.tx === 1'b0) low_run++;
      else still_low = 1'b0;
    end
    n_compared++;
    if (low_run != CPB_S) begin
      n_mismatched++;
      $display("[TB] FAIL full_start_bit: got %0d cycles low expected %0d", low_run, CPB_S);
    end
    n_compared++;
    if (busy_cyc != 20*CPB_S) begin
      n_mismatched++;
      $display("[TB] FAIL full_word_cycles: got %0d expected %0d", busy_cyc, 20*CPB_S);
    end
    n_compared++;
    if (bus_s.tx !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL full_idle_tx: got %b expected 1", bus_s.tx);
    end
  endtask

  initial begin
    clk            = 1'b0;
    rst            = 1'b1;
    n_compared     = 0;
    n_mismatched   = 0;
    n_log          = 0;
    bus_s.in_valid = 1'b0;
    bus_s.in_data  = '0;
    refresh_fifo();
    test_reset();
    test_single_word();
    test_back_to_back();
    test_continuous_valid();
    test_reset_mid_data();
    test_full_rate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
